dcs_txarb: RTL and testbench

//  Round-robin arbiter and sequencer for the shared UDP slow-control transmit path.

---
 rtl/dcs_txarb.sv | 139 +++++++++++++
 tb/tb_dcs_txarb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcs_txarb.sv
// dcs_txarb: round-robin grant of NCH DCS reply channels onto the UDP TX path,
// prepending the 4-byte port header and guarding against timeout and overlength frames.
module dcs_txarb #(
   parameter int          NCH              = 41,
   parameter logic [15:0] slowcontrol_port = 16'h1001,
   parameter logic [15:0] MAX_LEN          = 16'd1460,
   parameter logic [15:0] TIMEOUT          = 16'd4095,
   parameter logic [3:0]  IFG              = 4'd12
) (
   input  logic             udp_tx_clk,
   input  logic             reset,
   input  logic [NCH-1:0]   dcs_tx_req,
   output logic [NCH-1:0]   dcs_tx_gnt,
   input  logic [NCH*8-1:0] dcs_txd,
   input  logic [NCH-1:0]   dcs_tx_dv,
   input  logic [15:0]      udp_rx_src_port,
   input  logic             udp_tx_rdy,
   output logic [7:0]       udp_txd,
   output logic             udp_tx_dv,
   output logic [5:0]       udp_tx_chan,
   output logic             err_timeout,
   output logic             err_trunc
);
   localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, HDR = 3'd2, DATA = 3'd3,
                          TAIL = 3'd4, DRAIN = 3'd5, GAP = 3'd6;
   localparam logic [NCH-1:0] ONE = 1;

   logic [2:0]      state;
   logic [5:0]      ptr, win;
   logic [6:0]      j;
   logic [15:0]     dst, pcnt, tmo;
   logic [3:0]      gcnt;
   logic [1:0]      hc;
   logic            fin, dvg, acc;
   logic [7:0]      byte_g, hb;
   logic [3:0][7:0] dl;
   logic [3:0]      vl;

   // walk downwards so the requester closest after ptr is the last (winning) assignment
   always_comb begin
      win = ptr;
      j = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         j = 7'(ptr) + 7'(i) + 7'd1;
         j = (j >= 7'(NCH)) ? j - 7'(NCH) : j;
         win = dcs_tx_req[j[5:0]] ? j[5:0] : win;
      end
   end

   assign dvg    = dcs_tx_dv[udp_tx_chan];
   assign byte_g = dcs_txd[{udp_tx_chan, 3'b000} +: 8];
   assign acc    = dvg & ~fin & (pcnt < MAX_LEN);
   assign hb     = (hc == 2'd1) ? slowcontrol_port[7:0] : (hc == 2'd2) ? dst[15:8] : dst[7:0];

   always_ff @(posedge udp_tx_clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= 6'(NCH - 1);
         dcs_tx_gnt  <= '0;
         udp_tx_chan <= '0;
         udp_txd     <= '0;
         udp_tx_dv   <= 1'b0;
         err_timeout <= 1'b0;
         err_trunc   <= 1'b0;
         dst         <= '0;
         pcnt        <= '0;
         tmo         <= '0;
         gcnt        <= '0;
         hc          <= '0;
         fin         <= 1'b0;
         dl          <= '0;
         vl          <= '0;
      end else begin
         err_timeout <= 1'b0;
         err_trunc   <= 1'b0;
         case (state)
            IDLE: if (|dcs_tx_req && udp_tx_rdy) begin
               dcs_tx_gnt  <= ONE << win;
               udp_tx_chan <= win;
               ptr         <= win;
               dst         <= udp_rx_src_port;
               tmo         <= '0;
               vl          <= '0;
               state       <= WAIT;
            end
            WAIT: if (dvg) begin
               udp_txd   <= slowcontrol_port[15:8];
               udp_tx_dv <= 1'b1;
               dl        <= {dl[2:0], byte_g};
               vl        <= {vl[2:0], 1'b1};
               pcnt      <= 16'd1;
               hc        <= 2'd1;
               fin       <= 1'b0;
               state     <= HDR;
            end else if (tmo == TIMEOUT) begin
               err_timeout <= 1'b1;
               dcs_tx_gnt  <= '0;
               gcnt        <= '0;
               state       <= GAP;
            end else
               tmo <= tmo + 16'd1;
            HDR, DATA: begin
               dl   <= {dl[2:0], byte_g};
               vl   <= {vl[2:0], acc};
               pcnt <= pcnt + 16'(acc);
               if (state == HDR) begin
                  udp_txd <= hb;
                  hc      <= hc + 2'd1;
                  fin     <= fin | ~dvg;
                  if (hc == 2'd3) state <= (fin | ~dvg) ? TAIL : DATA;
               end else begin
                  udp_txd <= dl[3];
                  if (!dvg) state <= TAIL;
                  else if (!acc) begin
                     err_trunc <= 1'b1;
                     state     <= DRAIN;
                  end
               end
            end
            TAIL, DRAIN: begin
               dl        <= {dl[2:0], 8'h00};
               vl        <= {vl[2:0], 1'b0};
               udp_txd   <= vl[3] ? dl[3] : 8'h00;
               udp_tx_dv <= vl[3];
               if (!vl[3] && (state == TAIL || !dvg)) begin
                  dcs_tx_gnt <= '0;
                  gcnt       <= '0;
                  state      <= GAP;
               end
            end
            GAP: begin
               gcnt <= gcnt + 4'd1;
               if (gcnt == IFG - 4'd1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcs_txarb.sv
// tb_dcs_txarb: directed bench for dcs_txarb with a granted-channel byte source and a TX monitor.
module tb_dcs_txarb;
   logic         clk, reset, rdy;
   logic [40:0]  req, gnt, dv;
   logic [327:0] txd;
   logic [15:0]  port;
   logic [7:0]   otxd;
   logic         odv, eto, etr;
   logic [5:0]   chan;

   int checks = 0, errors = 0, cyc = 0;
   int src_len = 0, sent = 0;
   logic [7:0] pbuf [32];
   logic [7:0] rxq [$];
   int glog [$];
   int frames, dv_cnt, low_run, min_gap, nto, ntr, gnt_cyc, gfall_cyc, to_cyc;
   logic prev_dv;
   logic [40:0] prev_gnt;

   dcs_txarb #(.MAX_LEN(16'd8)) dut (
      .udp_tx_clk(clk), .reset(reset), .dcs_tx_req(req), .dcs_tx_gnt(gnt),
      .dcs_txd(txd), .dcs_tx_dv(dv), .udp_rx_src_port(port), .udp_tx_rdy(rdy),
      .udp_txd(otxd), .udp_tx_dv(odv), .udp_tx_chan(chan),
      .err_timeout(eto), .err_trunc(etr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // source: the granted channel streams pbuf[0..src_len-1] on consecutive cycles
   initial begin
      dv = '0;
      txd = '0;
      forever begin
         @(negedge clk);
         dv = '0;
         if (gnt == '0) sent = 0;
         else if (sent < src_len) begin
            dv[chan] = 1'b1;
            txd[chan*8 +: 8] = pbuf[sent];
            sent++;
         end
      end
   end

   initial begin
      prev_dv = 1'b0;
      prev_gnt = '0;
      forever begin
         @(negedge clk);
         if (odv) begin
            if (!prev_dv && frames > 0 && low_run < min_gap) min_gap = low_run;
            if (!prev_dv) frames++;
            rxq.push_back(otxd);
            dv_cnt++;
            low_run = 0;
         end else low_run++;
         if (gnt != '0 && prev_gnt == '0) begin
            glog.push_back(int'(chan));
            gnt_cyc = cyc;
         end
         if (gnt == '0 && prev_gnt != '0) gfall_cyc = cyc;
         if (eto) begin nto++; to_cyc = cyc; end
         if (etr) ntr++;
         prev_dv = odv;
         prev_gnt = gnt;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rxq.delete();
      glog.delete();
      frames = 0; dv_cnt = 0; low_run = 0; min_gap = 1000;
      nto = 0; ntr = 0; gnt_cyc = 0; gfall_cyc = 0; to_cyc = 0;
   endtask

   task automatic wait_gnt(input string tag);
      for (int i = 0; i < 100 && gnt == '0; i++) @(negedge clk);
      chk(tag, 64'(gnt != '0), 64'd1);
   endtask

   task automatic wait_done(input string tag, input int bound);
      for (int i = 0; i < bound && (gnt != '0 || odv); i++) @(negedge clk);
      chk(tag, 64'(gnt == '0 && !odv), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_hdr(input string tag, input logic [15:0] dstp);
      chk({tag, "_h0"}, 64'(rxq[0]), 64'h10);
      chk({tag, "_h1"}, 64'(rxq[1]), 64'h01);
      chk({tag, "_h2"}, 64'(rxq[2]), 64'(dstp[15:8]));
      chk({tag, "_h3"}, 64'(rxq[3]), 64'(dstp[7:0]));
   endtask

   initial begin
      reset = 1'b1;
      req = '0;
      rdy = 1'b1;
      port = 16'h1777;
      #12;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_dv", 64'(odv), 64'd0);
      chk("rst_txd", 64'(otxd), 64'd0);
      chk("rst_chan", 64'(chan), 64'd0);
      chk("rst_err", 64'({eto, etr}), 64'd0);

      // single request, 3-byte payload; src port changes after grant must not leak into header
      do_reset();
      pbuf[0] = 8'hAA; pbuf[1] = 8'hBB; pbuf[2] = 8'hCC;
      src_len = 3;
      req[5] = 1'b1;
      wait_gnt("t1_gnt_seen");
      chk("t1_gnt", 64'(gnt), 64'h20);
      chk("t1_chan", 64'(chan), 64'd5);
      req = '0;
      port = 16'hBEEF;
      wait_done("t1_done", 100);
      chk("t1_len", 64'(rxq.size()), 64'd7);
      chk_hdr("t1", 16'h1777);
      chk("t1_b0", 64'(rxq[4]), 64'hAA);
      chk("t1_b1", 64'(rxq[5]), 64'hBB);
      chk("t1_b2", 64'(rxq[6]), 64'hCC);
      chk("t1_frames", 64'(frames), 64'd1);
      port = 16'h1777;

      // round robin across ch0, ch3, ch40 with requests held
      do_reset();
      pbuf[0] = 8'h11; pbuf[1] = 8'h22;
      src_len = 2;
      req[0] = 1'b1; req[3] = 1'b1; req[40] = 1'b1;
      for (int i = 0; i < 400 && glog.size() < 4; i++) @(negedge clk);
      chk("rr_cnt", 64'(glog.size() >= 4), 64'd1);
      chk("rr_g0", 64'(glog[0]), 64'd0);
      chk("rr_g1", 64'(glog[1]), 64'd3);
      chk("rr_g2", 64'(glog[2]), 64'd40);
      chk("rr_g3", 64'(glog[3]), 64'd0);
      chk("rr_gap", 64'(frames >= 3 && min_gap >= 13), 64'd1);
      req = '0;

      // timeout: ch7 granted but never sends
      do_reset();
      src_len = 0;
      req[7] = 1'b1;
      wait_gnt("to_gnt_seen");
      req = '0;
      for (int i = 0; i < 5000 && nto == 0; i++) @(negedge clk);
      chk("to_seen", 64'(nto), 64'd1);
      chk("to_delay", 64'(to_cyc - gnt_cyc), 64'd4096);
      chk("to_nodv", 64'(dv_cnt), 64'd0);
      chk("to_gnt_off", 64'(gnt), 64'd0);
      req[3] = 1'b1; req[8] = 1'b1;
      for (int i = 0; i < 100 && glog.size() < 2; i++) @(negedge clk);
      chk("to_ptr", 64'(glog[1]), 64'd8);

      // truncation at MAX_LEN=8 with a 20-byte source frame
      do_reset();
      for (int i = 0; i < 20; i++) pbuf[i] = 8'(i + 1);
      src_len = 20;
      req[2] = 1'b1;
      wait_gnt("tr_gnt_seen");
      req = '0;
      wait_done("tr_done", 100);
      chk("tr_len", 64'(rxq.size()), 64'd12);
      chk_hdr("tr", 16'h1777);
      for (int i = 0; i < 8; i++) chk("tr_byte", 64'(rxq[4 + i]), 64'(i + 1));
      chk("tr_err", 64'(ntr), 64'd1);
      chk("tr_hold", 64'(gfall_cyc - gnt_cyc), 64'd21);
      chk("tr_frames", 64'(frames), 64'd1);

      // 1-byte payload, held off by udp_tx_rdy; rdy drop mid-frame ignored
      do_reset();
      rdy = 1'b0;
      pbuf[0] = 8'h5A;
      src_len = 1;
      req[9] = 1'b1;
      repeat (30) @(negedge clk);
      chk("rdy_hold", 64'(gnt), 64'd0);
      rdy = 1'b1;
      wait_gnt("sp_gnt_seen");
      chk("sp_chan", 64'(chan), 64'd9);
      req = '0;
      rdy = 1'b0;
      wait_done("sp_done", 100);
      chk("sp_len", 64'(rxq.size()), 64'd5);
      chk_hdr("sp", 16'h1777);
      chk("sp_b0", 64'(rxq[4]), 64'h5A);
      rdy = 1'b1;

      // async reset in the middle of DATA
      do_reset();
      for (int i = 0; i < 10; i++) pbuf[i] = 8'(8'h40 + i);
      src_len = 10;
      req[12] = 1'b1;
      wait_gnt("ar_gnt_seen");
      req = '0;
      for (int i = 0; i < 100 && rxq.size() < 6; i++) @(negedge clk);
      chk("ar_pre_dv", 64'(odv), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("ar_gnt", 64'(gnt), 64'd0);
      chk("ar_dv", 64'(odv), 64'd0);
      chk("ar_txd", 64'(otxd), 64'd0);
      chk("ar_chan", 64'(chan), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      src_len = 1;
      req[3] = 1'b1; req[20] = 1'b1;
      wait_gnt("ar_next_seen");
      chk("ar_next", 64'(chan), 64'd3);
      req = '0;
      wait_done("ar_done", 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
